frame_char_streamer: RTL and testbench
======================================

Name: frame_char_streamer

Overview:
- Downstream of the game FSM: consumes its 1344-bit `frame` text buffer and streams it, one character per handshake, to the character-display driver.
- Re-renders automatically whenever `frame` changes, and on an explicit refresh request.
- Decouples the wide, combinationally updated frame from the narrow, slow display write port.

Parameters:
- CHAR_W, 7, bits per character code.
- COLS, 32, characters per display row.
- ROWS, 6, display rows. NUM_CHARS = COLS*ROWS = 192; FRAME_W = CHAR_W*NUM_CHARS = 1344 (derived, not overridable).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- frame  in  FRAME_W  text buffer from game FSM. Character 0 = bits [FRAME_W-1 -: CHAR_W]; characters proceed MSB to LSB.
- refresh  in  1  request a full re-render even if `frame` is unchanged.
- char_ready  in  1  display driver accepts the character this cycle.
- char_valid  out  1  char_data/char_col/char_row hold a valid character.
- char_data  out  CHAR_W  character code.
- char_col  out  5  column 0..COLS-1.
- char_row  out  3  row 0..ROWS-1.
- busy  out  1  high in SEND and DONE.
- frame_done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; snapshot 0; last-rendered copy 0; `pending` 0; `first` 1 (forces a render after reset).
- Reset mid-stream aborts immediately. Nothing is resumed. The next render starts from character 0.
- Internal registers:
  - `snap`: FRAME_W shift register.
  - `last`: FRAME_W copy of the last rendered frame.
  - `idx`: 8-bit character counter.
  - `col`/`row` counters.
  - `pending`, `first` flags.
- `start` = `first` OR `refresh` OR `pending` OR (`frame` != `last`).
- IDLE:
  - When `start` is high: on the clock edge, `snap` <= `frame`; `last` <= `frame`; `idx`, `col`, `row` <= 0; `first`, `pending` <= 0; go to SEND.
  - Latency: `char_valid` is high in the first cycle after the edge at which the change is sampled.
- SEND:
  - `char_valid` = 1; `char_data` = `snap[FRAME_W-1 -: CHAR_W]`; `char_col` = `col`; `char_row` = `row`.
  - While `char_ready` is 0, all outputs hold stable.
  - On `char_valid && char_ready`: `snap` shifts left by CHAR_W (zero-fill); `idx`++.
  - Column/row update: if `col` == COLS-1, then `col` <= 0 and `row`++; else `col`++.
  - If `idx` == NUM_CHARS-1 at the handshake: go to DONE; `char_valid` is 0 next cycle.
  - Throughput: back-to-back handshakes allowed, one character per cycle with `char_ready` held high. A full frame takes exactly NUM_CHARS accepting cycles.
- DONE:
  - `frame_done` = 1 for exactly one cycle; `char_valid` = 0; next state IDLE.
  - `row`/`col` wrap to 0 here. They never reach ROWS or exceed COLS-1.
- Frame change or `refresh` during SEND or DONE:
  - The current stream completes from `snap`; it is not restarted or corrupted.
  - `pending` <= 1 if `refresh` is asserted, or `frame` != `last`, in any cycle of SEND/DONE.
  - From IDLE, the `pending` render starts the cycle after DONE.
  - Multiple requests during one stream collapse into a single follow-up render, which uses the `frame` value present at its start.
- `refresh` and a frame change in the same cycle cause one render only.
- `char_ready` high outside SEND is ignored.
- `busy` = 1 in SEND and DONE, 0 in IDLE.

Test Plan:
- Reset release with frame=all 7'b0110001 → `char_valid` high the next cycle with col=0,row=0,data=7'b0110001. With `char_ready` held high: 192 accepts in 192 cycles, last at col=31,row=5; then `frame_done`=1 for 1 cycle; then IDLE with `busy`=0.
- Backpressure: `char_ready` toggled 1,0,0,1 → `char_data`/`char_col`/`char_row` constant while `char_ready`=0. Exactly 2 characters accepted (idx 0,1); second at col=1,row=0.
- Row wrap: after 32 accepts, the next character shows col=0,row=1 and data = bits [1343-224 -: 7] of the frame.
- Frame changed at character 50 of a stream → the remaining 142 characters come from the old snapshot. `frame_done` pulses, then a new stream starts from the new frame at col=0,row=0. Exactly 2 `frame_done` pulses in total.
- Static frame, no refresh, for 500 cycles after a completed render → `char_valid` stays 0. A `refresh` pulse yields exactly one 192-character render with identical data.
- `rst` asserted at character 100 → outputs 0 asynchronously. After release, a full render from character 0 (the `first` flag), 192 accepts.

Source files
------------

// File: rtl/frame_char_streamer.sv
// Streams a wide text frame to a character display, one character per
// valid/ready handshake, re-rendering on frame change or refresh request.
module frame_char_streamer #(
    parameter  int CHAR_W    = 7,
    parameter  int COLS      = 32,
    parameter  int ROWS      = 6,
    localparam int NUM_CHARS = COLS * ROWS,
    localparam int FRAME_W   = CHAR_W * NUM_CHARS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               refresh,
    input  logic               char_ready,
    output logic               char_valid,
    output logic [CHAR_W-1:0]  char_data,
    output logic [4:0]         char_col,
    output logic [2:0]         char_row,
    output logic               busy,
    output logic               frame_done
);
    localparam logic [7:0] LAST_IDX = 8'(NUM_CHARS - 1);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] snap;
    logic [FRAME_W-1:0] last;
    logic [7:0]         idx;
    logic [4:0]         col;
    logic [2:0]         row;
    logic               pending;
    logic               first;
    logic               changed;
    logic               start;
    logic               accept;

    assign changed = (frame != last);
    assign start   = first | refresh | pending | changed;
    assign accept  = (state == SEND) & char_ready;

    // Character always comes from the top of the snapshot; it is zero outside SEND
    // because the snapshot is fully shifted out (or reset) by then.
    assign char_data = snap[FRAME_W-1 -: CHAR_W];
    assign char_col  = col;
    assign char_row  = row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        char_valid = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                char_valid = 1'b1;
                busy       = 1'b1;
                if (accept && (idx == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requests arriving mid-stream are folded into one pending follow-up render.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap    <= '0;
            last    <= '0;
            idx     <= '0;
            col     <= '0;
            row     <= '0;
            pending <= 1'b0;
            first   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap    <= frame;
                        last    <= frame;
                        idx     <= '0;
                        col     <= '0;
                        row     <= '0;
                        first   <= 1'b0;
                        pending <= 1'b0;
                    end
                end
                SEND: begin
                    if (refresh || changed) begin
                        pending <= 1'b1;
                    end
                    if (char_ready) begin
                        snap <= snap << CHAR_W;
                        idx  <= idx + 8'd1;
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= (row == LAST_ROW) ? 3'd0 : row + 3'd1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (refresh || changed) begin
                        pending <= 1'b1;
                    end
                    idx <= '0;
                    col <= '0;
                    row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_char_streamer.sv
// Self-checking bench for frame_char_streamer: fixed vector table, directed
// multi-cycle sequences and a randomized run against a stream-level model.
module tb_frame_char_streamer;
    localparam int CHAR_W    = 7;
    localparam int COLS      = 32;
    localparam int ROWS      = 6;
    localparam int NUM_CHARS = COLS * ROWS;
    localparam int FRAME_W   = CHAR_W * NUM_CHARS;

    logic               clk = 1'b0;
    logic               rst;
    logic [FRAME_W-1:0] frame;
    logic               refresh;
    logic               char_ready;
    logic               char_valid;
    logic [CHAR_W-1:0]  char_data;
    logic [4:0]         char_col;
    logic [2:0]         char_row;
    logic               busy;
    logic               frame_done;

    frame_char_streamer #(.CHAR_W(CHAR_W), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .refresh    (refresh),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_col   (char_col),
        .char_row   (char_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Stream-level model: mode 0 idle, 1 streaming character m_k of m_cap, 2 done.
    int                 m_mode;
    int                 m_k;
    bit                 m_first;
    bit                 m_pending;
    logic [FRAME_W-1:0] m_cap;
    logic [FRAME_W-1:0] m_last;

    int          accepts;
    int          dones;
    int          vld_cycles;
    logic [4:0]  acc_col;
    logic [2:0]  acc_row;
    logic [6:0]  wrap_data;
    logic [4:0]  wrap_col;
    logic [2:0]  wrap_row;

    typedef struct {
        logic       ready;
        logic       ev;
        logic [6:0] ed;
        logic [4:0] ec;
        logic [2:0] er;
        logic       eb;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [6:0] char_at(input logic [FRAME_W-1:0] f, input int k);
        return f[FRAME_W-1-CHAR_W*k -: CHAR_W];
    endfunction

    function automatic logic [FRAME_W-1:0] const_frame(input logic [6:0] c);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_CHARS; k++) f[FRAME_W-1-CHAR_W*k -: CHAR_W] = c;
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_CHARS; k++) f[FRAME_W-1-CHAR_W*k -: CHAR_W] = 7'($urandom);
        return f;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_first = 1; m_pending = 0; m_cap = '0; m_last = '0;
    endtask

    task automatic model_update();
        bit start;
        if (rst) begin
            model_reset();
            return;
        end
        start = m_first || refresh || m_pending || (frame != m_last);
        case (m_mode)
            0: if (start) begin
                m_cap = frame; m_last = frame; m_k = 0;
                m_first = 0; m_pending = 0; m_mode = 1;
            end
            1: begin
                if (refresh || frame != m_last) m_pending = 1;
                if (char_ready) begin
                    m_k++;
                    if (m_k == NUM_CHARS) m_mode = 2;
                end
            end
            default: begin
                if (refresh || frame != m_last) m_pending = 1;
                m_mode = 0;
            end
        endcase
    endtask

    task automatic check_outputs(input string name);
        logic       ev, eb, edn;
        logic [6:0] ed;
        logic [4:0] ec;
        logic [2:0] er;
        ev  = (m_mode == 1);
        eb  = (m_mode != 0);
        edn = (m_mode == 2);
        ed  = ev ? char_at(m_cap, m_k) : 7'd0;
        ec  = ev ? 5'(m_k % COLS) : 5'd0;
        er  = ev ? 3'(m_k / COLS) : 3'd0;
        n_vec++;
        if ({char_valid, char_data, char_col, char_row, busy, frame_done} !== {ev, ed, ec, er, eb, edn}) begin
            n_bad++;
            $display("FAIL %s t=%0t got v=%b d=%h c=%0d r=%0d busy=%b done=%b expected v=%b d=%h c=%0d r=%0d busy=%b done=%b",
                     name, $time, char_valid, char_data, char_col, char_row, busy, frame_done,
                     ev, ed, ec, er, eb, edn);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic half_check(input string name);
        @(negedge clk);
        check_outputs(name);
        if (char_valid) vld_cycles++;
        if (char_valid && char_ready) begin
            if (accepts == 32) begin
                wrap_data = char_data; wrap_col = char_col; wrap_row = char_row;
            end
            accepts++;
            acc_col = char_col;
            acc_row = char_row;
        end
        if (frame_done) dones++;
    endtask

    task automatic half_advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle(input string name);
        half_check(name);
        half_advance();
    endtask

    // Runs with char_ready high until want_dones pulses and idle, optionally
    // changing the frame or pulsing reset once a given number of accepts is reached.
    task automatic run_stream(input string name, input int want_dones, input int budget,
                              input int change_at, input logic [FRAME_W-1:0] newf, input int rst_at);
        bit hit;
        hit = 0;
        accepts = 0;
        dones = 0;
        for (int i = 0; i < budget; i++) begin
            char_ready = 1'b1;
            if (!hit && change_at >= 0 && accepts == change_at) begin
                frame = newf;
                hit = 1;
            end
            if (!hit && rst_at >= 0 && accepts == rst_at) begin
                hit = 1;
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs({name, "_async_rst"});
                cycle(name);
                cycle(name);
                rst = 1'b0;
                accepts = 0;
                dones = 0;
            end
            cycle(name);
            if (dones >= want_dones && m_mode == 0) break;
        end
        expect_int({name, "_done_pulses"}, dones, want_dones);
    endtask

    logic [FRAME_W-1:0] fa;
    logic [FRAME_W-1:0] fb;

    initial begin
        tbl[0] = '{ready: 1'b1, ev: 1'b0, ed: 7'h00, ec: 5'd0, er: 3'd0, eb: 1'b0};
        tbl[1] = '{ready: 1'b1, ev: 1'b1, ed: 7'h31, ec: 5'd0, er: 3'd0, eb: 1'b1};
        tbl[2] = '{ready: 1'b0, ev: 1'b1, ed: 7'h31, ec: 5'd1, er: 3'd0, eb: 1'b1};
        tbl[3] = '{ready: 1'b0, ev: 1'b1, ed: 7'h31, ec: 5'd1, er: 3'd0, eb: 1'b1};
        tbl[4] = '{ready: 1'b1, ev: 1'b1, ed: 7'h31, ec: 5'd1, er: 3'd0, eb: 1'b1};
        tbl[5] = '{ready: 1'b0, ev: 1'b1, ed: 7'h31, ec: 5'd2, er: 3'd0, eb: 1'b1};

        rst = 1'b1;
        frame = const_frame(7'b0110001);
        refresh = 1'b0;
        char_ready = 1'b0;
        accepts = 0; dones = 0; vld_cycles = 0;
        acc_col = '0; acc_row = '0;
        wrap_data = '0; wrap_col = '0; wrap_row = '0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle("reset_hold");
        rst = 1'b0;

        // Reset release latency and backpressure 1,0,0,1
        for (int i = 0; i < 6; i++) begin
            char_ready = tbl[i].ready;
            half_check("table_model");
            n_vec++;
            if ({char_valid, char_data, char_col, char_row, busy} !== {tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].er, tbl[i].eb}) begin
                n_bad++;
                $display("FAIL table[%0d] got v=%b d=%h c=%0d r=%0d busy=%b expected v=%b d=%h c=%0d r=%0d busy=%b",
                         i, char_valid, char_data, char_col, char_row, busy,
                         tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].er, tbl[i].eb);
            end
            half_advance();
        end
        expect_int("table_accepts", accepts, 2);

        run_stream("first_render", 1, 400, -1, '0, -1);
        expect_int("first_render_accepts", accepts, NUM_CHARS - 2);
        expect_int("first_render_last_col", int'(acc_col), COLS - 1);
        expect_int("first_render_last_row", int'(acc_row), ROWS - 1);

        // Static frame stays silent, then a refresh re-renders once
        vld_cycles = 0;
        for (int i = 0; i < 500; i++) begin
            char_ready = 1'(i % 2);
            cycle("static_idle");
        end
        expect_int("static_idle_valid_cycles", vld_cycles, 0);
        refresh = 1'b1;
        cycle("refresh_pulse");
        refresh = 1'b0;
        run_stream("refresh_render", 1, 400, -1, '0, -1);
        expect_int("refresh_render_accepts", accepts, NUM_CHARS);

        // Frame change at character 50 finishes the old snapshot then re-renders
        fa = rand_frame();
        fb = rand_frame();
        frame = fa;
        run_stream("frame_change", 2, 1000, 50, fb, -1);
        expect_int("frame_change_accepts", accepts, 2 * NUM_CHARS);
        expect_int("row_wrap_data", int'(wrap_data), int'(char_at(fa, 32)));
        expect_int("row_wrap_col", int'(wrap_col), 0);
        expect_int("row_wrap_row", int'(wrap_row), 1);

        // Reset at character 100 aborts; first flag forces a full render
        refresh = 1'b1;
        cycle("refresh_pulse2");
        refresh = 1'b0;
        run_stream("mid_reset", 1, 1000, -1, '0, 100);
        expect_int("mid_reset_accepts", accepts, NUM_CHARS);

        // Randomized backpressure, refreshes and frame edits
        for (int i = 0; i < 3000; i++) begin
            int k;
            char_ready = ($urandom % 3) != 0;
            refresh = ($urandom % 60) == 0;
            if (($urandom % 150) == 0) begin
                k = int'($urandom % NUM_CHARS);
                frame[FRAME_W-1-CHAR_W*k -: CHAR_W] = 7'($urandom);
            end
            cycle("random");
        end
        refresh = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
